// File: rtl/opo_package.sv
// ---------------------------------------------------------------------------
// opo_package
//   Shared definitions for the interpolate_2 datapath.
//   word_width      : sample width in bits (signed two's complement)
//   interp2_state_t : control state of the 2x interpolator
// ---------------------------------------------------------------------------
package opo_package;

    localparam int word_width = 14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MID  = 2'd1,
        LAST = 2'd2
    } interp2_state_t;

endpackage

// File: rtl/interpolate_2.sv
// ---------------------------------------------------------------------------
// interpolate_2
//   Linear 2x interpolator with pass-through mode.
//   With enable=1 at acceptance, each accepted x[n] produces two outputs:
//   the midpoint (x[n-1]+x[n])>>>1, then x[n]. With enable=0 the sample is
//   forwarded one cycle after acceptance. A new sample may be accepted in
//   the LAST cycle, so back-to-back interpolation streams without gaps.
//
// Ports
//   clk             : clock, rising edge
//   rst             : synchronous active-high reset
//   enable          : 1 = interpolate by 2, 0 = pass-through
//   sample_in       : signed input sample
//   sample_in_valid : sample_in is valid
//   sample_in_ready : block can accept sample_in this cycle (low only in MID)
//   sample_out      : signed output sample, registered, holds when idle
//   sample_out_valid: one-cycle strobe per output sample
// ---------------------------------------------------------------------------
import opo_package::*;

module interpolate_2 (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [word_width-1:0] sample_in,
    input  logic                  sample_in_valid,
    output logic                  sample_in_ready,
    output logic [word_width-1:0] sample_out,
    output logic                  sample_out_valid
);

    interp2_state_t        state;
    interp2_state_t        state_next;
    logic [word_width-1:0] history;
    logic [word_width:0]   sum;
    logic [word_width-1:0] midpoint;
    logic                  accept;

    assign sample_in_ready = (state != MID);
    assign accept          = sample_in_valid && sample_in_ready;

    // One extra bit keeps the sum exact; dropping bit 0 is a floor shift.
    always_comb begin
        sum      = {history[word_width-1], history} + {sample_in[word_width-1], sample_in};
        midpoint = sum[word_width:1];
    end

    always_comb begin
        state_next = state;
        case (state)
            MID:     state_next = LAST;
            default: begin
                if (accept && enable) begin
                    state_next = MID;
                end else begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    // In MID the history already holds x[n], so it doubles as the pending
    // LAST output; ready is low there, so it cannot change underneath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            history          <= '0;
            sample_out       <= '0;
            sample_out_valid <= 1'b0;
        end else begin
            state            <= state_next;
            sample_out_valid <= 1'b0;
            if (accept) begin
                history          <= sample_in;
                sample_out       <= enable ? midpoint : sample_in;
                sample_out_valid <= 1'b1;
            end else if (state == MID) begin
                sample_out       <= history;
                sample_out_valid <= 1'b1;
            end
        end
    end

endmodule
